// File: rtl/fp2_pkg.sv
// Shared Fp2 definitions: field width, fp2_sub latency, requester ID type
// and the round-robin pick helper used by the scheduler arbiter.
package fp2_pkg;

  localparam int unsigned FP_W            = 255;
  localparam int unsigned FP2_SUB_LATENCY = 6;
  localparam int unsigned MAX_REQ         = 8;
  localparam int unsigned REQ_IDW         = 3;

  typedef logic [REQ_IDW-1:0] req_id_t;

  // One-hot grant: first set bit of valid at or above ptr, wrapping modulo n.
  // Bits at or above n are never granted.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                input req_id_t             ptr,
                                                input int unsigned         n);
    logic [MAX_REQ-1:0] gnt;
    logic               found;
    int unsigned        idx;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      if (k < n) begin
        idx = (32'(ptr) + k) % n;
        if (!found && valid[idx[REQ_IDW-1:0]]) begin
          gnt[idx[REQ_IDW-1:0]] = 1'b1;
          found                 = 1'b1;
        end
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/fp2_sub_sched_rr_arbiter.sv
// Round-robin arbiter: pointer register plus combinational one-hot pick.
// The pointer moves to one past the winner on every grant.
module rr_arbiter
  import fp2_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDW     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDW-1:0]     gnt_id_o,
  output logic               gnt_any_o
);

  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [MAX_REQ-1:0] valid_ext;
  logic [MAX_REQ-1:0] pick;
  logic               unused_pick_hi;

  // Grant selection and winner encoding.
  always_comb begin
    valid_ext                = '0;
    valid_ext[NUM_REQ-1:0]   = req_i;
    pick                     = rr_pick(valid_ext, req_id_t'(ptr_q), NUM_REQ);
    gnt_o                    = en_i ? pick[NUM_REQ-1:0] : '0;
    gnt_any_o                = |gnt_o;
    gnt_id_o                 = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_o[i]) gnt_id_o = IDW'(i);
    end
  end

  assign unused_pick_hi = ^(pick >> NUM_REQ);

  // Next pointer: one past the winner, wrapping at NUM_REQ.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any_o) begin
      ptr_d = (gnt_id_o == IDW'(NUM_REQ - 1)) ? '0 : gnt_id_o + IDW'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/fp2_sub_sched.sv
// Round-robin scheduler sharing one pipelined fp2_sub between NUM_REQ
// requesters. A valid/ID tag pipeline of LATENCY+1 stages returns each
// result to its originating requester.
// Optional statistics counters: define FP2_SUB_SCHED_STATS_EN.
module fp2_sub_sched
  import fp2_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned W       = FP_W,
  parameter int unsigned LATENCY = FP2_SUB_LATENCY,
  parameter int unsigned IDW     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sched_en,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*W-1:0] req_a1,
  input  logic [NUM_REQ*W-1:0] req_b1,
  input  logic [NUM_REQ*W-1:0] req_a2,
  input  logic [NUM_REQ*W-1:0] req_b2,
  output logic [W-1:0]         sub_A1,
  output logic [W-1:0]         sub_B1,
  output logic [W-1:0]         sub_A2,
  output logic [W-1:0]         sub_B2,
  input  logic [W-1:0]         sub_D1,
  input  logic [W-1:0]         sub_D2,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [W-1:0]         rsp_d1,
  output logic [W-1:0]         rsp_d2,
`ifdef FP2_SUB_SCHED_STATS_EN
  output logic [31:0]          stat_issued,
  output logic [NUM_REQ*16-1:0] stat_grant,
`endif
  output logic                 idle
);

  logic               gnt_any;
  logic [IDW-1:0]     gnt_id;
  logic [W-1:0]       a1_q, b1_q, a2_q, b2_q;
  logic [W-1:0]       a1_d, b1_d, a2_d, b2_d;
  logic [LATENCY:0]   tag_vld_q;
  logic [IDW-1:0]     tag_id_q [LATENCY+1];

  // Grants are held off while reset is asserted so req_ready reads 0.
  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .en_i      (sched_en & ~rst),
    .req_i     (req_valid),
    .gnt_o     (req_ready),
    .gnt_id_o  (gnt_id),
    .gnt_any_o (gnt_any)
  );

  // Operand mux: load the winner's operands, otherwise hold.
  always_comb begin
    a1_d = a1_q;
    b1_d = b1_q;
    a2_d = a2_q;
    b2_d = b2_q;
    if (gnt_any) begin
      a1_d = req_a1[32'(gnt_id)*W +: W];
      b1_d = req_b1[32'(gnt_id)*W +: W];
      a2_d = req_a2[32'(gnt_id)*W +: W];
      b2_d = req_b2[32'(gnt_id)*W +: W];
    end
  end

  // Operand registers feeding fp2_sub.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a1_q <= '0;
      b1_q <= '0;
      a2_q <= '0;
      b2_q <= '0;
    end else begin
      a1_q <= a1_d;
      b1_q <= b1_d;
      a2_q <= a2_d;
      b2_q <= b2_d;
    end
  end

  // Tag pipeline: shifts every cycle, stage 0 captures this cycle's grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld_q <= '0;
      for (int unsigned s = 0; s <= LATENCY; s++) tag_id_q[s] <= '0;
    end else begin
      tag_vld_q   <= {tag_vld_q[LATENCY-1:0], gnt_any};
      tag_id_q[0] <= gnt_id;
      for (int unsigned s = 1; s <= LATENCY; s++) tag_id_q[s] <= tag_id_q[s-1];
    end
  end

  assign sub_A1    = a1_q;
  assign sub_B1    = b1_q;
  assign sub_A2    = a2_q;
  assign sub_B2    = b2_q;
  assign rsp_valid = tag_vld_q[LATENCY];
  assign rsp_id    = tag_id_q[LATENCY];
  assign rsp_d1    = sub_D1;
  assign rsp_d2    = sub_D2;
  assign idle      = ~(|tag_vld_q) & ~gnt_any;

`ifdef FP2_SUB_SCHED_STATS_EN
  logic [31:0]          issued_q;
  logic [NUM_REQ*16-1:0] grant_q;

  // Saturating grant counters, total and per requester.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued_q <= '0;
      grant_q  <= '0;
    end else if (gnt_any) begin
      if (issued_q != '1) issued_q <= issued_q + 32'd1;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] && grant_q[i*16 +: 16] != '1)
          grant_q[i*16 +: 16] <= grant_q[i*16 +: 16] + 16'd1;
      end
    end
  end

  assign stat_issued = issued_q;
  assign stat_grant  = grant_q;
`endif

endmodule
